// File: rtl/nor_serial_adder.sv
// Digit-serial adder built from 2-input NOR full-adder cells, start/done handshake.
// Optional subtract mode enabled by defining NOR_ADD_SUB_EN (adds the sub port).

module nor_gate (
  input  logic x,
  input  logic y,
  output logic z
);
  assign z = ~(x | y);
endmodule

// Nine-NOR full adder: n4 is xnor(a,b); s is xnor(n4,ci) = a^b^ci.
module nor_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic n1, n2, n3, n4, n5, n6, n7;

  nor_gate g1 (.x(a),  .y(b),  .z(n1));
  nor_gate g2 (.x(a),  .y(n1), .z(n2));
  nor_gate g3 (.x(b),  .y(n1), .z(n3));
  nor_gate g4 (.x(n2), .y(n3), .z(n4));
  nor_gate g5 (.x(n4), .y(ci), .z(n5));
  nor_gate g6 (.x(n4), .y(n5), .z(n6));
  nor_gate g7 (.x(ci), .y(n5), .z(n7));
  nor_gate g8 (.x(n6), .y(n7), .z(s));
  nor_gate g9 (.x(n1), .y(n5), .z(co));
endmodule

module nor_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NOR_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, b_load, res_next;
  logic             carry_q, carry_load;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] ds;
  logic             last, accept, step;

  assign last = (cnt_q == CW'(N - 1));
  assign step = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NOR_ADD_SUB_EN
  logic [WIDTH-1:0] bn;
  for (genvar i = 0; i < WIDTH; i++) begin : g_inv
    nor_gate u_inv (.x(b[i]), .y(b[i]), .z(bn[i]));
  end
  assign b_load     = sub ? bn : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
    nor_full_adder u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c[i]),
      .s  (ds[i]),
      .co (c[i+1])
    );
  end

  // Only the WIDTH-DIGIT previously produced bits need storage; the newest
  // digit enters at the MSB end and the full result is formed combinationally.
  if (DIGIT < WIDTH) begin : g_acc
    logic [WIDTH-DIGIT-1:0] acc_q;
    assign res_next = {ds, acc_q};
    always_ff @(posedge clk) begin
      if (rst)       acc_q <= '0;
      else if (step) acc_q <= res_next[WIDTH-1:DIGIT];
    end
  end else begin : g_noacc
    assign res_next = ds;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh    <= a;
            b_sh    <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          carry_q <= c[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            sum  <= res_next;
            cout <= c[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nor_serial_adder.sv
// Scoreboard bench: four adder instances (DIGIT = 1,2,4,8) driven independently,
// each checked against an arithmetic reference model.

module tb_nor_serial_adder;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int NOPS  = 24;

  typedef struct {
    logic [8:0] res;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fin = 0;

  task automatic chk(input string nm, input int lane, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h (cycle %0d)",
               lane, nm, got, want, cyc);
    end
  endtask

  // {cout, sum}: plain integer addition, or modular difference with no-borrow flag.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic su);
    int t;
    if (su) begin
      t = int'(x) - int'(y);
      return {(int'(x) >= int'(y)), 8'(t)};
    end
    t = int'(x) + int'(y) + int'(ci);
    return 9'(t);
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : lane
    localparam int D = 1 << g;
    localparam int N = WIDTH / D;
    localparam int R = (N >= 3) ? 3 : N;

    logic       rst, start, cin, sub_sel, busy, done, cout;
    logic [7:0] a, b, sum;
    logic [8:0] exp_v, last_res;
    exp_t       q[$];
    exp_t       e;

    nor_serial_adder #(.WIDTH(WIDTH), .DIGIT(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef NOR_ADD_SUB_EN
      .sub   (sub_sel),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
    );

    initial begin : drv
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_sel = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", g, busy, 0);
      chk("reset_done", g, done, 0);
      chk("reset_sum",  g, sum,  0);
      chk("reset_cout", g, cout, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int k = 0; k < NOPS; k++) begin
        if (k == 8) begin
          // abort an operation mid-flight with reset
          start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
          @(posedge clk); #1;
          start = 1'b0;
          chk("abort_busy", g, busy, 1);
          for (int r = 1; r < R; r++) begin
            @(posedge clk); #1;
          end
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          @(negedge clk);
          chk("abort_busy0", g, busy, 0);
          chk("abort_done0", g, done, 0);
          chk("abort_sum0",  g, sum,  0);
          chk("abort_cout0", g, cout, 0);
          @(posedge clk); #1;
        end

        if (k == 0) begin
          a = 8'hFF; b = 8'h01; cin = 1'b0; sub_sel = 1'b0;
        end else if (k == 1) begin
          a = 8'h5A; b = 8'h33; cin = 1'b1; sub_sel = 1'b0;
`ifdef NOR_ADD_SUB_EN
        end else if (k == 2) begin
          a = 8'h10; b = 8'h20; cin = 1'($urandom); sub_sel = 1'b1;
        end else if (k == 3) begin
          a = 8'h20; b = 8'h10; cin = 1'($urandom); sub_sel = 1'b1;
`endif
        end else begin
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef NOR_ADD_SUB_EN
          sub_sel = 1'($urandom);
`else
          sub_sel = 1'b0;
`endif
        end
        start = 1'b1;
        exp_v = model(a, b, cin, sub_sel);
        @(posedge clk); #1;
        q.push_back('{res: exp_v, at: cyc + N});
        chk("busy_run", g, busy, 1);

        // noise on start and operands through RUN and DONE must be ignored
        for (int j = 0; j <= N; j++) begin
          start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef NOR_ADD_SUB_EN
          sub_sel = 1'($urandom);
`endif
          @(posedge clk); #1;
        end

        if (k < 8 && (k % 2) == 1) begin
          start = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
          end
        end
      end

      start = 1'b0;
      repeat (N + 4) @(posedge clk);
      #1;
      chk("queue_empty", g, q.size(), 0);
      n_fin++;
    end

    always @(negedge clk) begin : mon
      if (rst) begin
        last_res = '0;
      end else if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL lane%0d unexpected_done: got done=1 expected done=0 (cycle %0d)",
                   g, cyc);
        end else begin
          e = q.pop_front();
          chk("sum",        g, sum,  e.res[7:0]);
          chk("cout",       g, cout, e.res[8]);
          chk("done_cycle", g, cyc,  e.at);
          chk("busy_done",  g, busy, 1);
          last_res = e.res;
        end
      end else begin
        chk("hold", g, {cout, sum}, last_res);
      end
    end
  end

  initial begin
    for (int t = 0; t < 20000 && n_fin < LANES; t++) @(posedge clk);
    if (n_fin < LANES) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: lanes finished %0d expected %0d", n_fin, LANES);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
